local_net_interface: RTL

- Endpoint network interface attached to a router's local (L) port. It is the far end of the router's local data/valid/credit link.
- TX side: packetizes processing-element (PE) requests into fixed-length flit packets (header + payload). Injects them under credit-based flow control, tracking free slots in the router's local input buffer.
- RX side: buffers flits ejected by the router, hands them to the PE with a ready/valid handshake, and returns one credit pulse per flit consumed.

---
 rtl/local_net_interface.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/local_net_interface.sv
// Router local-port endpoint: packetizes PE requests into credit-controlled flits
// and buffers ejected flits for the PE, returning one credit per flit consumed.
module local_net_interface #(
  parameter int PKT_LEN    = 4,
  parameter int TX_CREDITS = 8,
  parameter int RX_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tx_start_i,
  input  logic [15:0] tx_dest_i,
  output logic        tx_busy_o,
  input  logic [15:0] tx_data_i,
  input  logic        tx_data_valid_i,
  output logic        tx_data_ready_o,
  output logic [15:0] net_data_o,
  output logic        net_valid_o,
  input  logic        net_credit_i,
  input  logic [15:0] net_data_i,
  input  logic        net_valid_i,
  output logic        net_credit_o,
  output logic [15:0] rx_data_o,
  output logic        rx_valid_o,
  output logic        rx_head_o,
  input  logic        rx_ready_i,
  output logic        credit_err_o,
  output logic        rx_overflow_o
);

  localparam int CW = $clog2(TX_CREDITS + 1);
  localparam int AW = $clog2(RX_DEPTH);
  localparam int BW = (PKT_LEN > 2) ? $clog2(PKT_LEN - 1) : 1;
  localparam int IW = $clog2(PKT_LEN);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAD = 2'd1,
    ST_BODY = 2'd2
  } tx_state_t;

  tx_state_t     state_r, state_s;
  logic [CW-1:0] credit_r;
  logic [15:0]   dest_r;
  logic [15:0]   flit_s;
  logic [15:0]   net_data_r;
  logic          net_valid_r;
  logic [BW-1:0] beat_r, beat_s;
  logic          send_s;
  logic          ready_s;
  logic          have_credit_s;
  logic          credit_err_r;

  assign have_credit_s = (credit_r != {CW{1'b0}});

  // TX next-state, emitted flit and payload handshake
  always_comb begin
    state_s = state_r;
    beat_s  = beat_r;
    send_s  = 1'b0;
    flit_s  = 16'h0000;
    ready_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (tx_start_i) begin
          state_s = ST_HEAD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_HEAD: begin
        if (have_credit_s) begin
          send_s  = 1'b1;
          flit_s  = dest_r;
          beat_s  = {BW{1'b0}};
          state_s = ST_BODY;
        end else begin
          state_s = ST_HEAD;
        end
      end
      ST_BODY: begin
        ready_s = have_credit_s;
        if (tx_data_valid_i && have_credit_s) begin
          send_s = 1'b1;
          flit_s = tx_data_i;
          if (beat_r == BW'(PKT_LEN - 2)) begin
            beat_s  = {BW{1'b0}};
            state_s = ST_IDLE;
          end else begin
            beat_s  = beat_r + BW'(1);
            state_s = ST_BODY;
          end
        end else begin
          state_s = ST_BODY;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // TX state, destination latch and registered link outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      beat_r      <= {BW{1'b0}};
      dest_r      <= 16'h0000;
      net_data_r  <= 16'h0000;
      net_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      beat_r      <= beat_s;
      net_valid_r <= send_s;
      if (state_r == ST_IDLE && tx_start_i) begin
        dest_r <= tx_dest_i;
      end
      if (send_s) begin
        net_data_r <= flit_s;
      end
    end
  end

  // Credit counter: a send and a returned credit in one cycle cancel out
  always_ff @(posedge clk) begin
    if (reset) begin
      credit_r     <= CW'(TX_CREDITS);
      credit_err_r <= 1'b0;
    end else begin
      case ({send_s, net_credit_i})
        2'b10: credit_r <= credit_r - CW'(1);
        2'b01: begin
          if (credit_r == CW'(TX_CREDITS)) begin
            credit_err_r <= 1'b1;
          end else begin
            credit_r <= credit_r + CW'(1);
          end
        end
        default: credit_r <= credit_r;
      endcase
    end
  end

  logic [15:0]   mem_r [RX_DEPTH];
  logic [AW:0]   wr_ptr_r, rd_ptr_r;
  logic [IW-1:0] rx_idx_r;
  logic          empty_s, full_s, pop_s, push_s;
  logic          net_credit_r, rx_overflow_r;

  // Extra pointer bit distinguishes full from empty when the indices match
  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign pop_s   = !empty_s && rx_ready_i;
  assign push_s  = net_valid_i && (!full_s || pop_s);

  // RX storage; contents need no reset since reads are gated by empty
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= net_data_i;
    end
  end

  // RX pointers, flit index, credit return and overflow flag
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r      <= {(AW+1){1'b0}};
      rd_ptr_r      <= {(AW+1){1'b0}};
      rx_idx_r      <= {IW{1'b0}};
      net_credit_r  <= 1'b0;
      rx_overflow_r <= 1'b0;
    end else begin
      net_credit_r <= pop_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
        if (rx_idx_r == IW'(PKT_LEN - 1)) begin
          rx_idx_r <= {IW{1'b0}};
        end else begin
          rx_idx_r <= rx_idx_r + IW'(1);
        end
      end
      if (net_valid_i && full_s && !pop_s) begin
        rx_overflow_r <= 1'b1;
      end
    end
  end

  assign tx_busy_o       = (state_r != ST_IDLE);
  assign tx_data_ready_o = ready_s;
  assign net_data_o      = net_data_r;
  assign net_valid_o     = net_valid_r;
  assign credit_err_o    = credit_err_r;
  assign net_credit_o    = net_credit_r;
  assign rx_valid_o      = !empty_s;
  assign rx_data_o       = empty_s ? 16'h0000 : mem_r[rd_ptr_r[AW-1:0]];
  assign rx_head_o       = !empty_s && (rx_idx_r == {IW{1'b0}});
  assign rx_overflow_o   = rx_overflow_r;

endmodule
